// File: rtl/iso_rx_lane_deframer_if.sv
// Lane-0 iso symbol input and deframed pixel/status outputs of iso_rx_lane_deframer.
// master: the symbol source / consumer side; slave: the deframer itself.
interface iso_rx_lane_deframer_if #(
    parameter int PIX_W = 24,
    parameter int CNT_W = 16
);
    logic             rx_en;
    logic [7:0]       iso_symbols_lane0;
    logic             iso_control_sym_flag_lane0;

    logic [PIX_W-1:0] rx_pixel_data;
    logic             rx_pixel_vld;
    logic             rx_line_start;
    logic             rx_line_end;
    logic [CNT_W-1:0] rx_line_px_cnt;
    logic [7:0]       rx_vbid;
    logic             rx_vblank;
    logic [7:0]       rx_mvid;
    logic [7:0]       rx_maud;
    logic             rx_locked;
    logic             rx_err;

    modport master (
        output rx_en, iso_symbols_lane0, iso_control_sym_flag_lane0,
        input  rx_pixel_data, rx_pixel_vld, rx_line_start, rx_line_end, rx_line_px_cnt,
        input  rx_vbid, rx_vblank, rx_mvid, rx_maud, rx_locked, rx_err
    );

    modport slave (
        input  rx_en, iso_symbols_lane0, iso_control_sym_flag_lane0,
        output rx_pixel_data, rx_pixel_vld, rx_line_start, rx_line_end, rx_line_px_cnt,
        output rx_vbid, rx_vblank, rx_mvid, rx_maud, rx_locked, rx_err
    );
endinterface

// File: rtl/iso_rx_lane_deframer.sv
// iso_rx_lane_deframer: single-lane isochronous symbol deframer (24bpp RGB).
// Tracks BS/SR/BE/FS/FE/SS/SE framing, captures VB-ID/Mvid/Maud, drops fill and
// secondary data, and repacks active data bytes into pixels. All outputs registered.
// Optional build macro: ISO_RX_SR_CHECK_EN enables the every-512th-marker SR check.
module iso_rx_lane_deframer #(
    parameter int PIX_W   = 24,
    parameter int HDR_LEN = 3,
    parameter int CNT_W   = 16
) (
    input  logic                  ls_clk,
    input  logic                  rst,
    iso_rx_lane_deframer_if.slave bus
);
    localparam int BPP  = PIX_W / 8;
    localparam int BC_W = $clog2(BPP + 1);

    localparam logic [7:0] K_BS = 8'hBC;
    localparam logic [7:0] K_SR = 8'h1C;
    localparam logic [7:0] K_BE = 8'hFB;
    localparam logic [7:0] K_FS = 8'hFE;
    localparam logic [7:0] K_FE = 8'hF7;
    localparam logic [7:0] K_SS = 8'h5C;
    localparam logic [7:0] K_SE = 8'hFD;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_BLANK  = 3'd2;
    localparam logic [2:0] ST_SEC    = 3'd3;
    localparam logic [2:0] ST_ACTIVE = 3'd4;
    localparam logic [2:0] ST_FILL   = 3'd5;

    logic [2:0]       state;
    logic [7:0]       hdr_idx;
    logic [BC_W-1:0]  byte_cnt;
    logic [CNT_W-1:0] px_cnt;
    logic [PIX_W-1:0] pix_sr;
    logic [PIX_W-1:0] pix_next;

    logic [PIX_W-1:0] pixel_data;
    logic             pixel_vld;
    logic             line_start;
    logic             line_end;
    logic [CNT_W-1:0] line_px_cnt;
    logic [7:0]       vbid;
    logic [7:0]       mvid;
    logic [7:0]       maud;
    logic             locked;
    logic             err;

    logic [7:0] sym;
    logic       is_ctrl;
    logic       is_bs, is_sr, is_be, is_fs, is_fe, is_ss, is_se;
    logic       is_marker, is_known;
    logic       fault;
    logic       sr_err;

    assign sym     = bus.iso_symbols_lane0;
    assign is_ctrl = bus.iso_control_sym_flag_lane0;

    assign is_bs     = is_ctrl && (sym == K_BS);
    assign is_sr     = is_ctrl && (sym == K_SR);
    assign is_be     = is_ctrl && (sym == K_BE);
    assign is_fs     = is_ctrl && (sym == K_FS);
    assign is_fe     = is_ctrl && (sym == K_FE);
    assign is_ss     = is_ctrl && (sym == K_SS);
    assign is_se     = is_ctrl && (sym == K_SE);
    assign is_marker = is_bs || is_sr;
    assign is_known  = is_marker || is_be || is_fs || is_fe || is_ss || is_se;

    // Newest byte enters at the bottom so the first byte of a pixel ends up in the top lane.
    assign pix_next = {pix_sr[PIX_W-9:0], sym};

    // Decide whether the qualified control symbol is a protocol violation in the current state.
    always_comb begin
        // NOTE: default assigned first so no path leaves fault unassigned (no latch).
        fault = 1'b0;
        if (bus.rx_en && is_ctrl && (state != ST_HUNT)) begin
            if (!is_known) begin
                fault = 1'b1;
            end else begin
                case (state)
                    ST_HDR:    fault = 1'b1;
                    ST_BLANK:  fault = !(is_ss || is_be || is_marker);
                    ST_SEC:    fault = !(is_se || is_ss);
                    ST_ACTIVE: fault = !(is_fs || is_marker);
                    ST_FILL:   fault = !(is_fe || is_marker);
                    default:   fault = 1'b1;
                endcase
            end
        end
    end

`ifdef ISO_RX_SR_CHECK_EN
    logic [8:0] sr_cnt;

    // Every 512th line marker must be SR: flag misplaced markers, resync on every SR.
    assign sr_err = bus.rx_en && ((is_sr && (sr_cnt != 9'd511)) || (is_bs && (sr_cnt == 9'd511)));

    // Count BS markers since the last SR; wraps naturally after a missing SR.
    always_ff @(posedge ls_clk) begin
        if (rst) begin
            sr_cnt <= '0;
        end else if (bus.rx_en) begin
            if (is_sr) begin
                sr_cnt <= '0;
            end else if (is_bs) begin
                sr_cnt <= sr_cnt + 9'd1;
            end
        end
    end
`else
    assign sr_err = 1'b0;
`endif

    // Framing FSM, header capture, pixel repacking and all registered outputs.
    always_ff @(posedge ls_clk) begin
        if (rst) begin
            state       <= ST_HUNT;
            hdr_idx     <= '0;
            byte_cnt    <= '0;
            px_cnt      <= '0;
            pix_sr      <= '0;
            pixel_data  <= '0;
            pixel_vld   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            line_px_cnt <= '0;
            vbid        <= '0;
            mvid        <= '0;
            maud        <= '0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first; a later assignment in this block overrides them,
            // which makes every pulse output a single-cycle strobe.
            pixel_vld  <= 1'b0;
            line_start <= 1'b0;
            line_end   <= 1'b0;
            err        <= sr_err;

            if (bus.rx_en) begin
                if (fault) begin
                    err    <= 1'b1;
                    locked <= 1'b0;
                    state  <= ST_HUNT;
                end else if (is_ctrl) begin
                    case (state)
                        ST_HUNT: begin
                            if (is_marker) begin
                                state   <= ST_HDR;
                                hdr_idx <= '0;
                            end
                        end
                        ST_BLANK: begin
                            if (is_ss) begin
                                state <= ST_SEC;
                            end else if (is_be) begin
                                state      <= ST_ACTIVE;
                                line_start <= 1'b1;
                                byte_cnt   <= '0;
                                px_cnt     <= '0;
                            end else begin
                                state   <= ST_HDR;
                                hdr_idx <= '0;
                            end
                        end
                        ST_SEC: begin
                            if (is_se) begin
                                state <= ST_BLANK;
                            end
                        end
                        ST_ACTIVE, ST_FILL: begin
                            if (is_marker) begin
                                line_end    <= 1'b1;
                                line_px_cnt <= px_cnt;
                                if (byte_cnt != '0) begin
                                    err <= 1'b1;
                                end
                                byte_cnt <= '0;
                                state    <= ST_HDR;
                                hdr_idx  <= '0;
                            end else if (is_fs) begin
                                state <= ST_FILL;
                            end else begin
                                state <= ST_ACTIVE;
                            end
                        end
                        default: state <= ST_HUNT;
                    endcase
                end else begin
                    case (state)
                        ST_HDR: begin
                            case (hdr_idx)
                                8'd0:    vbid <= sym;
                                8'd1:    mvid <= sym;
                                8'd2:    maud <= sym;
                                default: ;
                            endcase
                            if (hdr_idx == 8'(HDR_LEN - 1)) begin
                                state  <= ST_BLANK;
                                locked <= 1'b1;
                            end else begin
                                hdr_idx <= hdr_idx + 8'd1;
                            end
                        end
                        ST_ACTIVE: begin
                            pix_sr <= pix_next;
                            if (byte_cnt == BC_W'(BPP - 1)) begin
                                byte_cnt   <= '0;
                                pixel_data <= pix_next;
                                pixel_vld  <= 1'b1;
                                if (px_cnt != '1) begin
                                    px_cnt <= px_cnt + CNT_W'(1);
                                end
                            end else begin
                                byte_cnt <= byte_cnt + BC_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.rx_pixel_data  = pixel_data;
    assign bus.rx_pixel_vld   = pixel_vld;
    assign bus.rx_line_start  = line_start;
    assign bus.rx_line_end    = line_end;
    assign bus.rx_line_px_cnt = line_px_cnt;
    assign bus.rx_vbid        = vbid;
    assign bus.rx_vblank      = vbid[0];
    assign bus.rx_mvid        = mvid;
    assign bus.rx_maud        = maud;
    assign bus.rx_locked      = locked;
    assign bus.rx_err         = err;
endmodule

// File: tb/tb_iso_rx_lane_deframer.sv
// Self-checking bench for iso_rx_lane_deframer: directed framing cases with literal
// expectations, then randomized line streams checked every cycle against a
// symbol-level behavioural model. Optional ISO_RX_SR_CHECK_EN section at the end.
module tb_iso_rx_lane_deframer;
    typedef enum {M_HUNT, M_HDR, M_BLANK, M_SEC, M_ACT, M_FILL} phase_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iso_rx_lane_deframer_if bus ();

    iso_rx_lane_deframer dut (
        .ls_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;
    bit rnd_en = 1'b0;

    // Behavioural model state and expected outputs.
    phase_t     ph = M_HUNT;
    logic [7:0] m_q[$];
    int         m_hi = 0;
    logic [15:0] m_pc = '0;
    logic [23:0] e_pix = '0;
    logic        e_vld = 0, e_start = 0, e_end = 0, e_err = 0, e_locked = 0;
    logic [15:0] e_lpc = '0;
    logic [7:0]  e_vbid = '0, e_mvid = '0, e_maud = '0;

    // Pulse monitors for directed segments.
    int seg_vld = 0, seg_start = 0, seg_end = 0, seg_err = 0;
    logic [23:0] seg_first_pix = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Symbol-level reference: what one qualified symbol does to the outputs.
    task automatic model(input logic r, input logic en, input logic c, input logic [7:0] s);
        bit mark, known, ok;
        e_vld = 0; e_start = 0; e_end = 0; e_err = 0;
        if (r) begin
            ph = M_HUNT; m_q.delete(); m_pc = '0; m_hi = 0;
            e_pix = '0; e_lpc = '0; e_vbid = '0; e_mvid = '0; e_maud = '0; e_locked = 0;
            return;
        end
        if (!en) return;
        if (c) begin
            mark  = (s == 8'hBC) || (s == 8'h1C);
            known = mark || (s inside {8'hFB, 8'hFE, 8'hF7, 8'h5C, 8'hFD});
            ok    = 0;
            if (ph == M_HUNT) begin
                if (mark) begin ph = M_HDR; m_hi = 0; end
                return;
            end
            if (known) begin
                case (ph)
                    M_BLANK: begin
                        if (s == 8'h5C) begin ph = M_SEC; ok = 1; end
                        else if (s == 8'hFB) begin
                            ph = M_ACT; e_start = 1; m_q.delete(); m_pc = '0; ok = 1;
                        end else if (mark) begin ph = M_HDR; m_hi = 0; ok = 1; end
                    end
                    M_SEC: begin
                        if (s == 8'hFD) begin ph = M_BLANK; ok = 1; end
                        else if (s == 8'h5C) ok = 1;
                    end
                    M_ACT, M_FILL: begin
                        if (mark) begin
                            e_end = 1; e_lpc = m_pc;
                            if (m_q.size() != 0) e_err = 1;
                            m_q.delete(); ph = M_HDR; m_hi = 0; ok = 1;
                        end else if (ph == M_ACT && s == 8'hFE) begin ph = M_FILL; ok = 1; end
                        else if (ph == M_FILL && s == 8'hF7) begin ph = M_ACT; ok = 1; end
                    end
                    default: ok = 0;
                endcase
            end
            if (!ok) begin e_err = 1; ph = M_HUNT; e_locked = 0; end
        end else begin
            if (ph == M_HDR) begin
                if (m_hi == 0) e_vbid = s;
                else if (m_hi == 1) e_mvid = s;
                else e_maud = s;
                m_hi++;
                if (m_hi == 3) begin ph = M_BLANK; e_locked = 1; end
            end else if (ph == M_ACT) begin
                m_q.push_back(s);
                if (m_q.size() == 3) begin
                    e_pix = {m_q[0], m_q[1], m_q[2]};
                    e_vld = 1;
                    if (m_pc != 16'hFFFF) m_pc++;
                    m_q.delete();
                end
            end
        end
    endtask

    // NOTE: inputs change 1 time unit after the falling edge, never near the sampling edge.
    task automatic step(input logic r, input logic en, input logic c, input logic [7:0] s);
        @(negedge clk);
        #1;
        rst = r;
        bus.rx_en = en;
        bus.iso_control_sym_flag_lane0 = c;
        bus.iso_symbols_lane0 = s;
        @(posedge clk);
        model(r, en, c, s);
    endtask

    task automatic d(input logic [7:0] s);
        step(1'b0, rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1, 1'b0, s);
    endtask

    task automatic k(input logic [7:0] s);
        step(1'b0, rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1, 1'b1, s);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic hdr(input logic [7:0] v, input logic [7:0] mv, input logic [7:0] ma);
        d(v); d(mv); d(ma);
    endtask

    task automatic seg_clear();
        seg_vld = 0; seg_start = 0; seg_end = 0; seg_err = 0; seg_first_pix = '0;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("pixel_data", bus.rx_pixel_data, e_pix);
            check("pixel_vld", bus.rx_pixel_vld, e_vld);
            check("line_start", bus.rx_line_start, e_start);
            check("line_end", bus.rx_line_end, e_end);
            check("line_px_cnt", bus.rx_line_px_cnt, e_lpc);
            check("vbid", bus.rx_vbid, e_vbid);
            check("vblank", bus.rx_vblank, e_vbid[0]);
            check("mvid", bus.rx_mvid, e_mvid);
            check("maud", bus.rx_maud, e_maud);
            check("locked", bus.rx_locked, e_locked);
            check("err", bus.rx_err, e_err);
        end
    end

    // Pulse counters used by the directed literal checks.
    always @(negedge clk) begin
        if (bus.rx_pixel_vld === 1'b1) begin
            if (seg_vld == 0) seg_first_pix = bus.rx_pixel_data;
            seg_vld++;
        end
        if (bus.rx_line_start === 1'b1) seg_start++;
        if (bus.rx_line_end === 1'b1) seg_end++;
        if (bus.rx_err === 1'b1) seg_err++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mk, inj;
        bus.rx_en = 1'b0;
        bus.iso_control_sym_flag_lane0 = 1'b0;
        bus.iso_symbols_lane0 = 8'h00;

        // Reset: everything zero.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        cmp_on = 1'b1;
        #2;
        check("rst_locked", bus.rx_locked, 0);
        check("rst_pix", bus.rx_pixel_data, 0);
        check("rst_vbid", bus.rx_vbid, 0);

        // Header capture.
        k(8'hBC); hdr(8'h01, 8'h12, 8'h34);
        #2;
        check("hdr_vbid", bus.rx_vbid, 8'h01);
        check("hdr_vblank", bus.rx_vblank, 1);
        check("hdr_mvid", bus.rx_mvid, 8'h12);
        check("hdr_maud", bus.rx_maud, 8'h34);
        check("hdr_locked", bus.rx_locked, 1);
        check("mdl_locked", e_locked, 1);

        // Two pixels, one line.
        seg_clear();
        k(8'hFB);
        d(8'h11); d(8'h22); d(8'h33); d(8'h44); d(8'h55); d(8'h66);
        k(8'hBC);
        idle(); #2;
        check("two_px_strobes", seg_vld, 2);
        check("two_px_first", seg_first_pix, 24'h112233);
        check("two_px_last", bus.rx_pixel_data, 24'h445566);
        check("two_px_lpc", bus.rx_line_px_cnt, 2);
        check("mdl_two_px_lpc", e_lpc, 2);
        check("two_px_start", seg_start, 1);
        check("two_px_end", seg_end, 1);
        check("two_px_err", seg_err, 0);
        hdr(8'h00, 8'h12, 8'h34);

        // Pixel straddling a fill region.
        seg_clear();
        k(8'hFB); d(8'h11); k(8'hFE); d(8'h00); d(8'h00); k(8'hF7); d(8'h22); d(8'h33);
        k(8'hBC);
        idle(); #2;
        check("fill_strobes", seg_vld, 1);
        check("fill_pix", seg_first_pix, 24'h112233);
        check("mdl_fill_pix", e_pix, 24'h112233);
        check("fill_err", seg_err, 0);
        check("fill_lpc", bus.rx_line_px_cnt, 1);
        hdr(8'h00, 8'h12, 8'h34);

        // Partial pixel at line end.
        seg_clear();
        k(8'hFB); d(8'h11); d(8'h22); k(8'hBC);
        idle(); #2;
        check("part_strobes", seg_vld, 0);
        check("part_err", seg_err, 1);
        check("part_end", seg_end, 1);
        check("part_lpc", bus.rx_line_px_cnt, 0);
        hdr(8'h00, 8'h12, 8'h34);

        // Illegal control code inside active data.
        seg_clear();
        k(8'hFB); d(8'h11); k(8'h3C); d(8'h44); d(8'h55); d(8'h66);
        idle(); #2;
        check("ill_err", seg_err, 1);
        check("ill_locked", bus.rx_locked, 0);
        check("ill_strobes", seg_vld, 0);
        check("ill_end", seg_end, 0);
        k(8'hBC); hdr(8'h00, 8'h12, 8'h34);
        #2;
        check("relock", bus.rx_locked, 1);

        // Reset in the middle of a line.
        k(8'hFB); d(8'h11); d(8'h22); d(8'h33); d(8'h44);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        #2;
        check("mid_rst_pix", bus.rx_pixel_data, 0);
        check("mid_rst_locked", bus.rx_locked, 0);
        check("mid_rst_mvid", bus.rx_mvid, 0);
        check("mid_rst_vld", bus.rx_pixel_vld, 0);

        // Randomized line stream with qualifier gaps and occasional protocol faults.
        rnd_en = 1'b1;
        for (int ln = 0; ln < 200; ln++) begin
`ifdef ISO_RX_SR_CHECK_EN
            mk = 8'hBC;
`else
            mk = ($urandom_range(0, 1) != 0) ? 8'hBC : 8'h1C;
`endif
            k(mk);
            hdr(8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                k(8'h5C);
                repeat ($urandom_range(0, 4)) d(8'($urandom));
                k(8'hFD);
            end
            if ($urandom_range(0, 4) != 0) begin
                k(8'hFB);
                for (int i = 0; i < int'($urandom_range(0, 12)); i++) begin
                    if ($urandom_range(0, 5) == 0) begin
                        k(8'hFE);
                        repeat ($urandom_range(0, 3)) d(8'($urandom));
                        k(8'hF7);
                    end
                    d(8'($urandom));
                end
            end
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: inj = 8'hFB;
                    1: inj = 8'hFE;
                    2: inj = 8'hF7;
                    3: inj = 8'hFD;
                    4: inj = 8'h3C;
                    default: inj = 8'($urandom);
                endcase
                k(inj);
            end
        end
        rnd_en = 1'b0;
        k(8'hBC);
        idle();
        idle();
        cmp_on = 1'b0;

`ifdef ISO_RX_SR_CHECK_EN
        // 511 BS markers, then SR in the 512th slot: no error.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (511) begin k(8'hBC); hdr(8'h00, 8'h00, 8'h00); end
        seg_clear();
        k(8'h1C);
        idle(); #2;
        check("sr_ok_err", seg_err, 0);
        // 511 BS markers, then BS again: error on the 512th.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (511) begin k(8'hBC); hdr(8'h00, 8'h00, 8'h00); end
        seg_clear();
        k(8'hBC);
        idle(); #2;
        check("sr_miss_err", seg_err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
